// File: rtl/axi_rd_rsp_pkg.sv
// Shared AXI read-responder encodings: response codes, burst types, beat size,
// FSM states and the per-beat response decode.
package axi_rd_rsp_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [2:0] SIZE_4B = 3'b010;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } rd_state_e;

  // Burst-level errors (bad size/type) outrank the per-beat window decode.
  function automatic logic [1:0] beat_resp(input logic [31:0] addr,
                                           input logic        burst_err,
                                           input logic [31:0] base,
                                           input logic [31:0] size);
    if (burst_err)
      return RESP_SLVERR;
    else if ((addr >= base) && ((addr - base) < size))
      return RESP_OKAY;
    else
      return RESP_DECERR;
  endfunction

endpackage

// File: rtl/axi_mm2s_rd_responder_if.sv
// AXI4 read address/data channel bundle used between a read master and the responder.
interface axi_mm2s_rd_responder_if;

  logic [31:0] ARADDR;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;

  modport master (
    output ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    input  ARREADY, RDATA, RRESP, RLAST, RVALID
  );

  modport slave (
    input  ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    output ARREADY, RDATA, RRESP, RLAST, RVALID
  );

endinterface

// File: rtl/axi_rd_beat_gen.sv
// Per-beat address, counter, data, response and last-flag generation for one read burst.
// Outputs are registered so they hold naturally while the master stalls.
module axi_rd_beat_gen
  import axi_rd_rsp_pkg::*;
#(
  parameter logic [31:0] C_ADDR_BASE = 32'h0000_0000,
  parameter logic [31:0] C_ADDR_SIZE = 32'h0001_0000,
  parameter logic [31:0] C_DATA_SEED = 32'h5a5a_5a5a
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        advance,
  input  logic [31:0] ar_addr,
  input  logic [7:0]  ar_len,
  input  logic [2:0]  ar_size,
  input  logic [1:0]  ar_burst,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast
);

  logic [31:0] beat_addr_q;
  logic [7:0]  beat_cnt_q;
  logic [7:0]  len_q;
  logic        fixed_q;
  logic        burst_err_q;

  logic        load_err;
  logic [31:0] next_addr;
  logic [7:0]  next_cnt;

  always_comb begin
    load_err  = (ar_size != SIZE_4B) || ar_burst[1];
    next_addr = fixed_q ? beat_addr_q : beat_addr_q + 32'd4;
    next_cnt  = beat_cnt_q + 8'd1;
  end

  // Accepting the last beat clears the payload so idle cycles present zeros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_addr_q <= '0;
      beat_cnt_q  <= '0;
      len_q       <= '0;
      fixed_q     <= 1'b0;
      burst_err_q <= 1'b0;
      rdata       <= '0;
      rresp       <= RESP_OKAY;
      rlast       <= 1'b0;
    end else if (load) begin
      beat_addr_q <= ar_addr;
      beat_cnt_q  <= '0;
      len_q       <= ar_len;
      fixed_q     <= (ar_burst == BURST_FIXED);
      burst_err_q <= load_err;
      rdata       <= ar_addr ^ C_DATA_SEED;
      rresp       <= beat_resp(ar_addr, load_err, C_ADDR_BASE, C_ADDR_SIZE);
      rlast       <= (ar_len == 8'd0);
    end else if (advance) begin
      if (rlast) begin
        rdata <= '0;
        rresp <= RESP_OKAY;
        rlast <= 1'b0;
      end else begin
        beat_addr_q <= next_addr;
        beat_cnt_q  <= next_cnt;
        rdata       <= next_addr ^ C_DATA_SEED;
        rresp       <= beat_resp(next_addr, burst_err_q, C_ADDR_BASE, C_ADDR_SIZE);
        rlast       <= (next_cnt == len_q);
      end
    end
  end

endmodule

// File: rtl/axi_mm2s_rd_responder.sv
// AXI4 read responder that synthesises data from the beat address, one burst at a time.
// Define AXI_RD_RSP_STALL_EN to insert one idle cycle after every C_STALL_PERIOD beats.
module axi_mm2s_rd_responder
  import axi_rd_rsp_pkg::*;
#(
  parameter logic [31:0] C_ADDR_BASE    = 32'h0000_0000,
  parameter logic [31:0] C_ADDR_SIZE    = 32'h0001_0000,
  parameter logic [31:0] C_DATA_SEED    = 32'h5a5a_5a5a,
  parameter int          C_STALL_PERIOD = 4
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESETN,
  axi_mm2s_rd_responder_if.slave        s_axi,
  output logic [15:0]                   BURST_CNT,
  output logic                          ERR_STICKY
);

`ifdef AXI_RD_RSP_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  rd_state_e   state_q;
  rd_state_e   state_d;
  logic        alive_q;
  logic        stall_q;
  logic [31:0] stall_cnt_q;
  logic        stall_due;

  logic        arready;
  logic        rvalid;
  logic        load;
  logic        advance;
  logic        done;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;

  assign stall_due = STALL_EN && (stall_cnt_q == 32'(C_STALL_PERIOD - 1));

  // alive_q keeps ARREADY low until the first edge after reset release.
  always_comb begin
    state_d = state_q;
    arready = 1'b0;
    rvalid  = 1'b0;
    load    = 1'b0;
    advance = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        arready = alive_q;
        if (alive_q && s_axi.ARVALID) begin
          load    = 1'b1;
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        rvalid = !stall_q;
        if (rvalid && s_axi.RREADY) begin
          advance = 1'b1;
          if (rlast) begin
            done    = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q <= ST_IDLE;
      alive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      alive_q <= 1'b1;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      stall_q     <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      stall_q <= 1'b0;
      if (load) begin
        stall_cnt_q <= '0;
      end else if (advance && !rlast) begin
        if (stall_due) begin
          stall_q     <= 1'b1;
          stall_cnt_q <= '0;
        end else begin
          stall_cnt_q <= stall_cnt_q + 32'd1;
        end
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      BURST_CNT  <= '0;
      ERR_STICKY <= 1'b0;
    end else begin
      if (done)
        BURST_CNT <= BURST_CNT + 16'd1;
      if (advance && (rresp != RESP_OKAY))
        ERR_STICKY <= 1'b1;
    end
  end

  axi_rd_beat_gen #(
    .C_ADDR_BASE (C_ADDR_BASE),
    .C_ADDR_SIZE (C_ADDR_SIZE),
    .C_DATA_SEED (C_DATA_SEED)
  ) u_beat_gen (
    .clk      (S_AXI_ACLK),
    .rst_n    (S_AXI_ARESETN),
    .load     (load),
    .advance  (advance),
    .ar_addr  (s_axi.ARADDR),
    .ar_len   (s_axi.ARLEN),
    .ar_size  (s_axi.ARSIZE),
    .ar_burst (s_axi.ARBURST),
    .rdata    (rdata),
    .rresp    (rresp),
    .rlast    (rlast)
  );

  assign s_axi.ARREADY = arready;
  assign s_axi.RVALID  = rvalid;
  assign s_axi.RDATA   = rdata;
  assign s_axi.RRESP   = rresp;
  assign s_axi.RLAST   = rlast;

endmodule

// File: tb/tb_axi_mm2s_rd_responder.sv
// Randomised bench for axi_mm2s_rd_responder against a burst-level reference model.
// Honours AXI_RD_RSP_STALL_EN so the same bench covers both builds.
module tb_axi_mm2s_rd_responder;

  localparam logic [31:0] SEED    = 32'h5a5a_5a5a;
  localparam longint      BASE    = 64'h0;
  localparam longint      SIZE    = 64'h1_0000;
  localparam int          STALL_P = 4;

  logic        clk;
  logic        rst_n;
  logic [15:0] burst_cnt;
  logic        err_sticky;

  axi_mm2s_rd_responder_if bus ();

  axi_mm2s_rd_responder dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .s_axi         (bus),
    .BURST_CNT     (burst_cnt),
    .ERR_STICKY    (err_sticky)
  );

  int          tests_run;
  int          tests_failed;
  logic [15:0] exp_burst_cnt;
  logic        exp_sticky;
  int          gaps_seen;
  logic [31:0] exp_data [256];
  logic [1:0]  exp_resp [256];
  logic [31:0] obs_data [256];
  logic [1:0]  obs_resp [256];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time exhausted");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [1:0] model_resp(input logic [31:0] addr, input logic [2:0] size,
                                            input logic [1:0] burst);
    longint a;
    a = longint'(addr);
    if (size != 3'b010 || burst == 2'b10 || burst == 2'b11) return 2'b10;
    if (a >= BASE && a < BASE + SIZE) return 2'b00;
    return 2'b11;
  endfunction

  // rmode: 0 random RREADY, 1 RREADY held high, 2 RREADY toggles starting low
  task automatic applyStimulus(input logic [31:0] addr, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst, input int rmode);
    int          idx;
    int          cyc;
    int          accepted;
    bit          gap;
    bit          rr;
    logic [31:0] a;
    for (int i = 0; i <= int'(len); i++) begin
      a = (burst == 2'b00) ? addr : addr + 32'(4 * i);
      exp_data[i] = a ^ SEED;
      exp_resp[i] = model_resp(a, size, burst);
    end
    gaps_seen = 0;
    @(negedge clk);
    bus.ARADDR  = addr;
    bus.ARLEN   = len;
    bus.ARSIZE  = size;
    bus.ARBURST = burst;
    bus.ARVALID = 1'b1;
    bus.RREADY  = 1'b0;
    checkOutput("arready_idle", 32'(bus.ARREADY), 32'd1);
    idx = 0; cyc = 0; accepted = 0; gap = 1'b0;
    while (idx <= int'(len) && cyc < 600) begin
      @(negedge clk);
      cyc++;
      bus.ARVALID = 1'($urandom_range(0, 1));
      bus.ARADDR  = $urandom();
      if (cyc == 1) checkOutput("arready_busy", 32'(bus.ARREADY), 32'd0);
      checkOutput("rvalid", 32'(bus.RVALID), 32'(!gap));
      if (!bus.RVALID) gaps_seen++;
      gap = 1'b0;
      if (bus.RVALID) begin
        if (burst < 2'b10) checkOutput("rdata", bus.RDATA, exp_data[idx]);
        checkOutput("rresp", 32'(bus.RRESP), 32'(exp_resp[idx]));
        checkOutput("rlast", 32'(bus.RLAST), 32'(idx == int'(len)));
      end
      case (rmode)
        1:       rr = 1'b1;
        2:       rr = (cyc % 2 == 0);
        default: rr = ($urandom_range(0, 3) != 0);
      endcase
      bus.RREADY = rr;
      if (bus.RVALID && rr) begin
        obs_data[idx] = bus.RDATA;
        obs_resp[idx] = bus.RRESP;
        if (exp_resp[idx] != 2'b00) exp_sticky = 1'b1;
        idx++;
        accepted++;
`ifdef AXI_RD_RSP_STALL_EN
        if (accepted % STALL_P == 0 && idx <= int'(len)) gap = 1'b1;
`endif
      end
    end
    if (idx <= int'(len))
      checkOutput("burst_timeout", 32'(idx), 32'(int'(len) + 1));
    else
      exp_burst_cnt = exp_burst_cnt + 16'd1;
    @(negedge clk);
    bus.ARVALID = 1'b0;
    bus.RREADY  = 1'b0;
    checkOutput("idle_rvalid", 32'(bus.RVALID), 32'd0);
    checkOutput("idle_arready", 32'(bus.ARREADY), 32'd1);
    checkOutput("burst_cnt", 32'(burst_cnt), 32'(exp_burst_cnt));
    checkOutput("err_sticky", 32'(err_sticky), 32'(exp_sticky));
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_arready"}, 32'(bus.ARREADY), 32'd0);
    checkOutput({tag, "_rvalid"}, 32'(bus.RVALID), 32'd0);
    checkOutput({tag, "_rlast"}, 32'(bus.RLAST), 32'd0);
    checkOutput({tag, "_rdata"}, bus.RDATA, 32'd0);
    checkOutput({tag, "_rresp"}, 32'(bus.RRESP), 32'd0);
    checkOutput({tag, "_burst_cnt"}, 32'(burst_cnt), 32'd0);
    checkOutput({tag, "_err_sticky"}, 32'(err_sticky), 32'd0);
  endtask

  task automatic resetMidBurst();
    @(negedge clk);
    bus.ARADDR = 32'h200; bus.ARLEN = 8'd7; bus.ARSIZE = 3'b010; bus.ARBURST = 2'b01;
    bus.ARVALID = 1'b1; bus.RREADY = 1'b1;
    @(negedge clk);
    bus.ARVALID = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("mid_rvalid", 32'(bus.RVALID), 32'd1);
    checkOutput("mid_rdata", bus.RDATA, 32'h208 ^ SEED);
    #2 rst_n = 1'b0;
    #1 checkResetOutputs("rst_mid");
    exp_burst_cnt = '0;
    exp_sticky    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 checkOutput("rel_arready", 32'(bus.ARREADY), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("post_rst_rvalid", 32'(bus.RVALID), 32'd0);
      checkOutput("post_rst_arready", 32'(bus.ARREADY), 32'd1);
    end
    bus.RREADY = 1'b0;
  endtask

  initial begin
    logic [31:0] addr;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          sel;
    tests_run = 0; tests_failed = 0;
    exp_burst_cnt = '0; exp_sticky = 1'b0;
    rst_n = 1'b0;
    bus.ARADDR = '0; bus.ARLEN = '0; bus.ARSIZE = 3'b010; bus.ARBURST = 2'b01;
    bus.ARVALID = 1'b0; bus.RREADY = 1'b0;
    #2 checkResetOutputs("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 checkOutput("rel0_arready", 32'(bus.ARREADY), 32'd0);
    @(negedge clk);
    checkOutput("rel1_arready", 32'(bus.ARREADY), 32'd1);

    applyStimulus(32'h100, 8'd3, 3'b010, 2'b01, 1);
    checkOutput("incr_d0", obs_data[0], 32'h5a5a5b5a);
    checkOutput("incr_d1", obs_data[1], 32'h5a5a5b5e);
    checkOutput("incr_d2", obs_data[2], 32'h5a5a5b52);
    checkOutput("incr_d3", obs_data[3], 32'h5a5a5b56);
    checkOutput("incr_cnt", 32'(burst_cnt), 32'd1);

    applyStimulus(32'h10, 8'd0, 3'b010, 2'b00, 2);
    checkOutput("fixed_d0", obs_data[0], 32'h5a5a5a4a);

    applyStimulus(32'h0000_FFFC, 8'd1, 3'b010, 2'b01, 0);
    checkOutput("edge_r0", 32'(obs_resp[0]), 32'd0);
    checkOutput("edge_r1", 32'(obs_resp[1]), 32'd3);

    applyStimulus(32'h40, 8'd1, 3'b011, 2'b01, 0);
    checkOutput("size_r1", 32'(obs_resp[1]), 32'd2);
    applyStimulus(32'h40, 8'd1, 3'b010, 2'b10, 0);
    checkOutput("wrap_r0", 32'(obs_resp[0]), 32'd2);
    checkOutput("sticky_err", 32'(err_sticky), 32'd1);

`ifdef AXI_RD_RSP_STALL_EN
    applyStimulus(32'h400, 8'd9, 3'b010, 2'b01, 1);
    checkOutput("stall_gaps", 32'(gaps_seen), 32'd2);
`else
    applyStimulus(32'h400, 8'd9, 3'b010, 2'b01, 1);
    checkOutput("nostall_gaps", 32'(gaps_seen), 32'd0);
`endif

    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0:       addr = {16'h0, $urandom_range(0, 16'hFFFF) & 32'hFFFC};
        1:       addr = 32'h0000_FFC0 + ($urandom_range(0, 15) * 4);
        2:       addr = 32'hFFFF_FFE0 + ($urandom_range(0, 7) * 4);
        default: addr = $urandom();
      endcase
      size  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'b010;
      burst = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      applyStimulus(addr, 8'($urandom_range(0, 15)), size, burst, 0);
    end

    resetMidBurst();
    applyStimulus(32'h80, 8'd2, 3'b010, 2'b01, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
